// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select pair with bounded grant dwell.
// Optional MUX_SEL_ARB_LOCK_EN adds a lock input that suspends the dwell limit.
module mux_sel_arbiter #(
    parameter int DWELL = 4,
    parameter int CW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
`ifdef MUX_SEL_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] LIMIT = CW'(DWELL - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    last;
    logic [1:0]    idx;
    logic [1:0]    cand;
    logic          found;
    logic          lock_hold;
    logic          release_now;

`ifdef MUX_SEL_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Search starts just past the last grant; offset 4 lands back on last,
    // so a sole requester can be re-granted.
    always_comb begin
        idx   = last;
        cand  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = (!lock_hold && (cnt == LIMIT)) || !req[last];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
            s1    <= 1'b0;
            s0    <= 1'b0;
            cnt   <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << idx;
                        s1    <= idx[1];
                        s0    <= idx[0];
                        valid <= 1'b1;
                        cnt   <= '0;
                        last  <= idx;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        if (found) begin
                            gnt   <= 4'b0001 << idx;
                            s1    <= idx[1];
                            s0    <= idx[0];
                            valid <= 1'b1;
                            cnt   <= '0;
                            last  <= idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            valid <= 1'b0;
                            cnt   <= '0;
                        end
                    end else if (!lock_hold) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    valid <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
